// File: rtl/acc_pkg.sv
// Shared register map, control codes and FSM encoding for the hash accelerator
// master (acc_driver) and its bus slave.
package acc_pkg;

    localparam int unsigned NUM_BLK_WORDS  = 16;
    localparam int unsigned NUM_HASH_WORDS = 8;

    // Block words live at 0..15, hash words are read back from 0..7.
    localparam logic [4:0] ADDR_CTRL   = 5'd16;
    localparam logic [4:0] ADDR_STATUS = 5'd17;

    localparam logic [31:0] CTRL_START   = 32'hFFFF_FFFF;
    localparam logic [31:0] CTRL_ACK     = 32'h0F0F_0F0F;
    localparam logic [31:0] CTRL_ABORT   = 32'hFF00_00FF;
    localparam logic [31:0] STATUS_READY = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_GO,
        ST_POLL,
        ST_PWAIT,
        ST_READ,
        ST_ACK,
        ST_ABORT
    } acc_state_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == '1) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/acc_driver.sv
// Bus master that loads a 512-bit block into the hash accelerator, starts it,
// polls for completion and reads back the 256-bit hash.
module acc_driver
    import acc_pkg::*;
#(
    parameter int POLL_TIMEOUT = 4096
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [511:0] blk,
    output logic         busy,
    output logic         hash_valid,
    output logic [255:0] hash,
    output logic         timeout_err,
    output logic         avm_chipselect,
    output logic         avm_write,
    output logic         avm_read,
    output logic [4:0]   avm_address,
    output logic [31:0]  avm_writedata,
    input  logic [31:0]  avm_readdata
);

    localparam logic [15:0] TIMEOUT_CNT = 16'(POLL_TIMEOUT);

    acc_state_e        state_q;
    acc_state_e        state_d;
    logic [3:0]        word_cnt;
    logic [15:0]       poll_cnt;
    logic [15:0][31:0] blk_q;
    logic [7:0][31:0]  hash_q;
    logic [2:0]        cap_idx;

    assign busy           = (state_q != ST_IDLE);
    assign hash           = hash_q;
    assign avm_chipselect = avm_write | avm_read;

    // Read data trails its strobe by one cycle, so the word landing now is
    // the one addressed with word_cnt-1 (word_cnt==8 wraps to index 7).
    assign cap_idx = word_cnt[2:0] - 3'd1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        avm_write     = 1'b0;
        avm_read      = 1'b0;
        avm_address   = '0;
        avm_writedata = '0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                avm_write     = 1'b1;
                avm_address   = {1'b0, word_cnt};
                avm_writedata = blk_q[word_cnt];
                if (word_cnt == 4'(NUM_BLK_WORDS - 1)) begin
                    state_d = ST_GO;
                end
            end
            ST_GO: begin
                avm_write     = 1'b1;
                avm_address   = ADDR_CTRL;
                avm_writedata = CTRL_START;
                state_d       = ST_POLL;
            end
            ST_POLL: begin
                avm_read    = 1'b1;
                avm_address = ADDR_STATUS;
                state_d     = ST_PWAIT;
            end
            ST_PWAIT: begin
                if (avm_readdata == STATUS_READY) begin
                    state_d = ST_READ;
                end else if (poll_cnt == TIMEOUT_CNT) begin
                    state_d = ST_ABORT;
                end else begin
                    state_d = ST_POLL;
                end
            end
            ST_READ: begin
                if (!word_cnt[3]) begin
                    avm_read    = 1'b1;
                    avm_address = {1'b0, word_cnt};
                end else begin
                    state_d = ST_ACK;
                end
            end
            ST_ACK: begin
                avm_write     = 1'b1;
                avm_address   = ADDR_CTRL;
                avm_writedata = CTRL_ACK;
                state_d       = ST_IDLE;
            end
            ST_ABORT: begin
                avm_write     = 1'b1;
                avm_address   = ADDR_CTRL;
                avm_writedata = CTRL_ABORT;
                state_d       = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            word_cnt    <= '0;
            poll_cnt    <= '0;
            blk_q       <= '0;
            hash_q      <= '0;
            hash_valid  <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            hash_valid  <= (state_q == ST_ACK);
            timeout_err <= (state_q == ST_ABORT);
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        blk_q    <= blk;
                        word_cnt <= '0;
                    end
                end
                ST_LOAD: begin
                    word_cnt <= word_cnt + 4'd1;
                    if (state_d == ST_GO) begin
                        poll_cnt <= '0;
                    end
                end
                ST_POLL: begin
                    poll_cnt <= sat_inc16(poll_cnt);
                end
                ST_PWAIT: begin
                    word_cnt <= '0;
                end
                ST_READ: begin
                    word_cnt <= word_cnt + 4'd1;
                    if (word_cnt != 4'd0) begin
                        hash_q[cap_idx] <= avm_readdata;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_acc_driver.sv
// Directed bench for acc_driver against a behavioural accelerator slave with
// registered read data, a configurable ready-after-N-polls status and a write log.
module tb_acc_driver;
    import acc_pkg::*;

    logic         clk;
    logic         reset_n;
    logic         start;
    logic [511:0] blk;
    logic         busy;
    logic         hash_valid;
    logic [255:0] hash;
    logic         timeout_err;
    logic         avm_chipselect;
    logic         avm_write;
    logic         avm_read;
    logic [4:0]   avm_address;
    logic [31:0]  avm_writedata;
    logic [31:0]  avm_readdata = '0;

    acc_driver #(.POLL_TIMEOUT(8)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .blk            (blk),
        .busy           (busy),
        .hash_valid     (hash_valid),
        .hash           (hash),
        .timeout_err    (timeout_err),
        .avm_chipselect (avm_chipselect),
        .avm_write      (avm_write),
        .avm_read       (avm_read),
        .avm_address    (avm_address),
        .avm_writedata  (avm_writedata),
        .avm_readdata   (avm_readdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_tests = 0;
    int n_fail  = 0;

    function automatic logic [31:0] hfn(input logic [31:0] a, input logic [31:0] c, input int j);
        return a ^ {c[15:0], c[31:16]} ^ (32'h0101_0101 * 32'(j));
    endfunction

    function automatic logic [511:0] mk_blk(input logic [31:0] base_w, input logic [31:0] step);
        logic [511:0] b;
        for (int k = 0; k < 16; k++) b[32*k +: 32] = base_w + step * 32'(k);
        return b;
    endfunction

    function automatic logic [255:0] exp_hash_of(input logic [511:0] b);
        logic [255:0] h;
        for (int j = 0; j < 8; j++) h[32*j +: 32] = hfn(b[64*j +: 32], b[64*j+32 +: 32], j);
        return h;
    endfunction

    // ---------------- accelerator model ----------------
    int          cyc_cnt = 0;
    int          model_ready = 1;
    int          polls_seen = 0;
    int          n_status_reads = 0;
    int          n_hash_reads = 0;
    logic [31:0] blk_regs [16];
    logic [31:0] hash_regs [8];
    logic [4:0]  wr_addr [$];
    logic [31:0] wr_data [$];
    int          wr_cyc [$];

    always @(posedge clk) begin
        cyc_cnt <= cyc_cnt + 1;
        if (avm_write) begin
            wr_addr.push_back(avm_address);
            wr_data.push_back(avm_writedata);
            wr_cyc.push_back(cyc_cnt);
            if (avm_address < 5'd16) begin
                blk_regs[avm_address[3:0]] <= avm_writedata;
            end else if (avm_address == ADDR_CTRL && avm_writedata == CTRL_START) begin
                polls_seen <= 0;
                for (int j = 0; j < 8; j++) hash_regs[j] <= hfn(blk_regs[2*j], blk_regs[2*j+1], j);
            end
        end
        if (avm_read) begin
            if (avm_address == ADDR_STATUS) begin
                n_status_reads <= n_status_reads + 1;
                polls_seen     <= polls_seen + 1;
                avm_readdata   <= (model_ready != 0 && polls_seen + 1 >= model_ready) ?
                                  STATUS_READY : 32'hFFFF_FFFE;
            end else if (avm_address < 5'd8) begin
                n_hash_reads <= n_hash_reads + 1;
                avm_readdata <= hash_regs[avm_address[2:0]];
            end else begin
                avm_readdata <= '0;
            end
        end
    end

    int bus_viol = 0;
    int bus_act  = 0;
    always @(negedge clk) begin
        if ((avm_read && avm_write) || (avm_chipselect != (avm_read | avm_write)) ||
            (!avm_read && !avm_write && (avm_address != '0 || avm_writedata != '0)))
            bus_viol <= bus_viol + 1;
        if (avm_chipselect || avm_read || avm_write)
            bus_act <= bus_act + 1;
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int first_bad_load(input logic [511:0] b, input int lb, input int base_c);
        for (int k = 0; k < 16; k++) begin
            if (wr_addr.size() <= lb + k) return k;
            if (wr_addr[lb+k] != 5'(k) || wr_data[lb+k] != b[32*k +: 32] ||
                wr_cyc[lb+k] - base_c != k + 1) return k;
        end
        if (wr_addr.size() <= lb + 16 || wr_addr[lb+16] != ADDR_CTRL ||
            wr_data[lb+16] != CTRL_START || wr_cyc[lb+16] - base_c != 17) return 16;
        return 17;
    endfunction

    int base_c, lb, st0, hr0;

    // Drives start at relative cycle 0 (and ignored extra starts at s1/s2 with a
    // scrambled blk), then waits for hash_valid or timeout_err; returns at the
    // falling edge of the pulse cycle.
    task automatic run_txn(input logic [511:0] b, input int ready, input int s1, input int s2,
                           output int pulse_rel, output bit was_to);
        @(posedge clk); #1;
        base_c      = cyc_cnt;
        lb          = wr_addr.size();
        st0         = n_status_reads;
        hr0         = n_hash_reads;
        model_ready = ready;
        pulse_rel   = -1;
        was_to      = 1'b0;
        for (int rel = 0; rel < 120; rel++) begin
            start = (rel == 0) || (rel == s1) || (rel == s2);
            blk   = (rel == 0) ? b : (start ? ~b : blk);
            @(negedge clk);
            if (hash_valid || timeout_err) begin
                pulse_rel = rel;
                was_to    = timeout_err;
                break;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
    endtask

    typedef struct {
        logic [511:0] b;
        int           ready;
        int           exp_pulse;
        int           exp_polls;
        bit           exp_to;
    } vec_t;

    vec_t         vecs [6];
    int           pulse;
    bit           to;
    logic [255:0] last_hash;
    logic [511:0] blk_a, blk_b;
    bit           found;
    int           act0;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{mk_blk(32'h0000_0000, 32'h0000_0001), 1, 30, 1, 1'b0};
        vecs[1] = '{mk_blk(32'hDEAD_0000, 32'h0001_1111), 3, 34, 3, 1'b0};
        vecs[2] = '{mk_blk(32'h8000_0001, 32'h1357_9BDF), 5, 38, 5, 1'b0};
        vecs[3] = '{mk_blk(32'hFFFF_FFF0, 32'h0F0F_0001), 8, 44, 8, 1'b0};
        vecs[4] = '{mk_blk(32'h1234_5678, 32'h1111_1111), 0, 35, 8, 1'b1};
        vecs[5] = '{mk_blk(32'hCAFE_BABE, 32'h0000_0101), 9, 35, 8, 1'b1};

        start   = 1'b0;
        blk     = '0;
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        #1;
        check("reset outputs", {busy, hash_valid, timeout_err, avm_chipselect, avm_write,
                                avm_read, avm_address, avm_writedata}, '0);
        check("reset hash", hash, '0);
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        last_hash = '0;
        for (int i = 0; i < 6; i++) begin
            run_txn(vecs[i].b, vecs[i].ready, -1, -1, pulse, to);
            check($sformatf("rec%0d pulse cycle", i), 256'(pulse), 256'(vecs[i].exp_pulse));
            check($sformatf("rec%0d timeout flag", i), 256'(to), 256'(vecs[i].exp_to));
            check($sformatf("rec%0d busy at pulse", i), 256'(busy), '0);
            check($sformatf("rec%0d status polls", i), 256'(n_status_reads - st0), 256'(vecs[i].exp_polls));
            check($sformatf("rec%0d hash reads", i), 256'(n_hash_reads - hr0), vecs[i].exp_to ? '0 : 256'(8));
            check($sformatf("rec%0d write count", i), 256'(wr_addr.size() - lb), 256'(18));
            check($sformatf("rec%0d load seq first bad", i), 256'(first_bad_load(vecs[i].b, lb, base_c)), 256'(17));
            if (wr_addr.size() > 0)
                check($sformatf("rec%0d final ctrl write", i),
                      {wr_addr[wr_addr.size()-1], wr_data[wr_data.size()-1]},
                      {ADDR_CTRL, vecs[i].exp_to ? CTRL_ABORT : CTRL_ACK});
            if (!vecs[i].exp_to) last_hash = exp_hash_of(vecs[i].b);
            check($sformatf("rec%0d hash", i), hash, last_hash);
        end

        // Extra starts during LOAD (cycle 5) and READ (cycle 22) must be ignored.
        blk_a = mk_blk(32'hA000_0000, 32'h0000_0003);
        run_txn(blk_a, 1, 5, 22, pulse, to);
        check("ign pulse cycle", 256'(pulse), 256'(30));
        check("ign timeout flag", 256'(to), '0);
        check("ign write count", 256'(wr_addr.size() - lb), 256'(18));
        check("ign load seq first bad", 256'(first_bad_load(blk_a, lb, base_c)), 256'(17));
        check("ign hash reads", 256'(n_hash_reads - hr0), 256'(8));
        check("ign hash", hash, exp_hash_of(blk_a));

        // start in the hash_valid cycle is accepted: LOAD of word 0 next cycle.
        blk_b = mk_blk(32'hB000_0000, 32'h0000_0005);
        blk   = blk_b;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("b2b load begins", {busy, avm_write, avm_address, avm_writedata},
              {1'b1, 1'b1, 5'd0, 32'hB000_0000});

        // Reset while the read strobe for hash word 3 is on the bus.
        found = 1'b0;
        for (int k = 0; k < 80; k++) begin
            if (avm_read && avm_address == 5'd3) begin
                found = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        check("reach READ word 3", 256'(found), 256'(1));
        #2 reset_n = 1'b0;
        #1;
        check("mid-READ reset outputs", {busy, hash_valid, timeout_err, avm_chipselect, avm_write,
                                         avm_read, avm_address, avm_writedata}, '0);
        check("mid-READ reset hash", hash, '0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        act0 = bus_act;
        repeat (20) @(posedge clk);
        #1;
        check("no bus after reset", 256'(bus_act - act0), '0);
        check("idle after reset", 256'(busy), '0);
        check("bus protocol violations", 256'(bus_viol), '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
